// File: rtl/rsa_result_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// rsa_result_scoreboard_pkg
//
// Shared definitions for the RSA result scoreboard.
//   - Default widths for the RAM address, plaintext and cipher text.
//   - The toy RSA key used by the datapath upstream: modulus N_MOD, public
//     exponent E_EXP and private exponent D_EXP. The hardware never computes
//     with them. They are here so that stimulus generators and reference models
//     use the same key as the datapath.
//   - Bit positions of every field inside a check record at the default
//     widths. A record is packed MSB to LSB as
//     {addr, pt, ct, pt_org, unwritten, match}.
//   - Helper functions: record width for arbitrary widths, and a modular
//     exponentiation used to produce cipher/plain text pairs.
// -----------------------------------------------------------------------------
package rsa_result_scoreboard_pkg;

    // Default datapath widths
    localparam int ADDR_W_DEF = 3;
    localparam int PT_W_DEF   = 5;
    localparam int CT_W_DEF   = 6;

    // Toy RSA key: 33 = 3 * 11, e*d = 21 = 1 mod lcm(2,10)
    localparam int N_MOD = 33;
    localparam int E_EXP = 7;
    localparam int D_EXP = 3;

    // Record field offsets (LSB positions) at the default widths
    localparam int REC_MATCH_BIT = 0;
    localparam int REC_UNWR_BIT  = 1;
    localparam int REC_PTORG_LSB = 2;
    localparam int REC_CT_LSB    = REC_PTORG_LSB + CT_W_DEF;
    localparam int REC_PT_LSB    = REC_CT_LSB + CT_W_DEF;
    localparam int REC_ADDR_LSB  = REC_PT_LSB + PT_W_DEF;
    localparam int REC_W         = REC_ADDR_LSB + ADDR_W_DEF;

    // Width of one record for a given set of datapath widths
    function automatic int rec_width(input int aw, input int pw, input int cw);
        return aw + pw + 2 * cw + 2;
    endfunction

    // base**exp mod modulus by repeated multiplication; operands are small
    // enough that the product never leaves 32 bits.
    function automatic int unsigned mod_pow(input int unsigned base,
                                            input int unsigned exp,
                                            input int unsigned modulus);
        int unsigned r;
        int unsigned b;
        r = 1;
        b = base % modulus;
        for (int unsigned i = 0; i < exp; i++) begin
            r = (r * b) % modulus;
        end
        return r;
    endfunction

endpackage : rsa_result_scoreboard_pkg

// File: rtl/rsa_rec_fifo.sv
// -----------------------------------------------------------------------------
// rsa_rec_fifo
//
// Synchronous record FIFO with a combinational head.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset, clears both pointers
//   push   in   write din at the tail this edge
//   pop    in   drop the head entry this edge (ignored when empty)
//   din    in   WIDTH  record to enqueue
//   full   out  DEPTH entries held
//   empty  out  no entries held
//   head   out  WIDTH  oldest entry, or zero when empty
//
// DEPTH must be a power of two and at least 2. Pointers carry one extra wrap
// bit so that full and empty can be told apart without an occupancy counter.
// A push while full is accepted only together with a pop; the tail slot then
// equals the head slot, which is read before the edge and overwritten at it.
// -----------------------------------------------------------------------------
module rsa_rec_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Zero when empty so that a freshly reset FIFO shows an all-zero record
    // regardless of what the storage still holds.
    assign head = empty ? '0 : mem[rd_ptr[PW-1:0]];

    // Pointer (control) state
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Record storage; contents behind the pointers are don't-care
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= din;
        end
    end

endmodule : rsa_rec_fifo

// File: rtl/rsa_result_scoreboard.sv
// -----------------------------------------------------------------------------
// rsa_result_scoreboard
//
// Watches the RSA encrypt/decrypt datapath and checks every decryption.
// Plaintext writes into the input RAM are shadowed per address. Cipher text is
// captured per address on each encryption-done pulse. On each decryption-done
// pulse the recovered plaintext is compared with the shadowed plaintext, and a
// record of the check is queued for readout.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   wren         in   plaintext RAM write enable (snooped)
//   wraddr       in   ADDR_W  plaintext RAM write address
//   pt           in   PT_W    plaintext being written
//   e_d          in   encryption-done pulse
//   ct_addr      in   ADDR_W  address the cipher text belongs to
//   cipher_text  in   CT_W    cipher text, valid with e_d
//   d_d          in   decryption-done pulse
//   dt_addr      in   ADDR_W  address being decrypted
//   pt_org       in   CT_W    recovered plaintext, valid with d_d
//   rec_valid    out  a record is available
//   rec_ready    in   consumer takes the head record when rec_valid is high
//   rec_data     out  REC     head record {addr, pt, ct, pt_org, unwritten, match}
//   pass_cnt     out  CNT_W   saturating count of matching checks
//   fail_cnt     out  CNT_W   saturating count of mismatching/unwritten checks
//   overflow     out  sticky: a record was dropped on a full FIFO
//   all_pass     out  at least one pass, no fail, no overflow
//
// A check reads the shadow tables before the edge, so a write or capture to
// the same address in the same cycle is compared against the old value and
// becomes visible one cycle later. Counters account for every check, even
// when its record is dropped.
// -----------------------------------------------------------------------------
module rsa_result_scoreboard
    import rsa_result_scoreboard_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int PT_W       = PT_W_DEF,
    parameter int CT_W       = CT_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wren,
    input  logic [ADDR_W-1:0]               wraddr,
    input  logic [PT_W-1:0]                 pt,
    input  logic                            e_d,
    input  logic [ADDR_W-1:0]               ct_addr,
    input  logic [CT_W-1:0]                 cipher_text,
    input  logic                            d_d,
    input  logic [ADDR_W-1:0]               dt_addr,
    input  logic [CT_W-1:0]                 pt_org,
    output logic                            rec_valid,
    input  logic                            rec_ready,
    output logic [ADDR_W+PT_W+2*CT_W+2-1:0] rec_data,
    output logic [CNT_W-1:0]                pass_cnt,
    output logic [CNT_W-1:0]                fail_cnt,
    output logic                            overflow,
    output logic                            all_pass
);

    localparam int ENTRIES = 2 ** ADDR_W;
    localparam int RW      = rec_width(ADDR_W, PT_W, CT_W);

    // Counter increment that holds at all ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Shadow copies of what the datapath has seen, per RAM address
    logic [PT_W-1:0]    shadow_pt [ENTRIES];
    logic [CT_W-1:0]    shadow_ct [ENTRIES];
    logic [ENTRIES-1:0] pt_valid;

    // Check stage
    logic               vld_p0;
    logic               unwritten_p0;
    logic               match_p0;
    logic [RW-1:0]      rec_p0;

    // FIFO handshake
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push;
    logic [RW-1:0]      fifo_head;

    // ---- p0: check formed from pre-edge tables ----
    always_comb begin
        vld_p0       = d_d;
        unwritten_p0 = !pt_valid[dt_addr];
        // Recovered plaintext is one bit wider than the stored plaintext, so a
        // set top bit is always a mismatch.
        match_p0     = pt_valid[dt_addr] && (pt_org == CT_W'(shadow_pt[dt_addr]));
        rec_p0       = {dt_addr, shadow_pt[dt_addr], shadow_ct[dt_addr],
                        pt_org, unwritten_p0, match_p0};
    end

    assign pop  = !fifo_empty && rec_ready;
    assign push = vld_p0 && (!fifo_full || pop);

    // ---- shadow tables, updated at the edge ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                shadow_pt[i] <= '0;
                shadow_ct[i] <= '0;
            end
            pt_valid <= '0;
        end else begin
            if (wren) begin
                shadow_pt[wraddr] <= pt;
                pt_valid[wraddr]  <= 1'b1;
            end
            if (e_d) begin
                shadow_ct[ct_addr] <= cipher_text;
            end
        end
    end

    // ---- p1: counters and sticky flags ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (vld_p0) begin
                if (match_p0) begin
                    pass_cnt <= sat_inc(pass_cnt);
                end else begin
                    fail_cnt <= sat_inc(fail_cnt);
                end
            end
            if (vld_p0 && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---- p1: record queue ----
    rsa_rec_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rec_p0),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign rec_valid = !fifo_empty;
    assign rec_data  = fifo_head;
    assign all_pass  = (pass_cnt != '0) && (fail_cnt == '0) && !overflow;

endmodule : rsa_result_scoreboard

// File: tb/tb_rsa_result_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_rsa_result_scoreboard
//
// Directed table of cycles with hand-computed expectations, a few hand-written
// multi-cycle sequences (FIFO overflow and drain, reset during a check, counter
// saturation), then randomized traffic compared each cycle against a queue
// based reference model.
// -----------------------------------------------------------------------------
module tb_rsa_result_scoreboard;
    import rsa_result_scoreboard_pkg::*;

    localparam int AW    = 3;
    localparam int PW    = 5;
    localparam int CW    = 6;
    localparam int DEPTH = 4;
    localparam int CNTW  = 8;
    localparam int RW    = AW + PW + 2 * CW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wren = 1'b0;
    logic [AW-1:0] wraddr = '0;
    logic [PW-1:0] pt = '0;
    logic          e_d = 1'b0;
    logic [AW-1:0] ct_addr = '0;
    logic [CW-1:0] cipher_text = '0;
    logic          d_d = 1'b0;
    logic [AW-1:0] dt_addr = '0;
    logic [CW-1:0] pt_org = '0;
    logic          rec_valid;
    logic          rec_ready = 1'b0;
    logic [RW-1:0] rec_data;
    logic [CNTW-1:0] pass_cnt;
    logic [CNTW-1:0] fail_cnt;
    logic          overflow;
    logic          all_pass;

    int n_total = 0;
    int n_pass  = 0;

    rsa_result_scoreboard #(
        .ADDR_W(AW), .PT_W(PW), .CT_W(CW), .FIFO_DEPTH(DEPTH), .CNT_W(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .wren(wren), .wraddr(wraddr), .pt(pt),
        .e_d(e_d), .ct_addr(ct_addr), .cipher_text(cipher_text),
        .d_d(d_d), .dt_addr(dt_addr), .pt_org(pt_org),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .overflow(overflow),
        .all_pass(all_pass)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    logic [PW-1:0] m_pt [8];
    logic [CW-1:0] m_ct [8];
    bit            m_v  [8];
    logic [RW-1:0] m_q  [$];
    int            m_pass;
    int            m_fail;
    bit            m_ovf;

    function automatic logic [RW-1:0] mkrec(input logic [AW-1:0] a, input logic [PW-1:0] p,
                                            input logic [CW-1:0] c, input logic [CW-1:0] po,
                                            input logic u, input logic m);
        return {a, p, c, po, u, m};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_model(input string tag);
        logic [RW-1:0] exp_d;
        bit            exp_ap;
        exp_d  = (m_q.size() > 0) ? m_q[0] : '0;
        exp_ap = (m_pass != 0) && (m_fail == 0) && !m_ovf;
        chk({tag, ".rec_valid"}, 32'(rec_valid), 32'(m_q.size() > 0));
        chk({tag, ".rec_data"},  32'(rec_data),  32'(exp_d));
        chk({tag, ".pass_cnt"},  32'(pass_cnt),  32'(m_pass));
        chk({tag, ".fail_cnt"},  32'(fail_cnt),  32'(m_fail));
        chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, ".all_pass"},  32'(all_pass),  32'(exp_ap));
    endtask

    // One clock cycle: drive inputs, advance the model, step the clock, and
    // optionally compare all outputs with the model.
    task automatic step(input bit chk_model, input logic r, input logic w,
                        input logic [AW-1:0] wa, input logic [PW-1:0] p,
                        input logic ed, input logic [AW-1:0] ca, input logic [CW-1:0] c,
                        input logic dd, input logic [AW-1:0] da, input logic [CW-1:0] po,
                        input logic rr);
        logic [RW-1:0] rec;
        bit            mt;
        rst = r; wren = w; wraddr = wa; pt = p; e_d = ed; ct_addr = ca; cipher_text = c;
        d_d = dd; dt_addr = da; pt_org = po; rec_ready = rr;
        if (r) begin
            for (int i = 0; i < 8; i++) begin
                m_pt[i] = '0; m_ct[i] = '0; m_v[i] = 0;
            end
            m_q.delete();
            m_pass = 0; m_fail = 0; m_ovf = 0;
        end else begin
            mt  = m_v[da] && (int'(po) == int'(m_pt[da]));
            rec = mkrec(da, m_pt[da], m_ct[da], po, !m_v[da], mt);
            if (rr && m_q.size() > 0) void'(m_q.pop_front());
            if (dd) begin
                if (m_q.size() < DEPTH) m_q.push_back(rec);
                else m_ovf = 1;
                if (mt) m_pass = (m_pass < 255) ? m_pass + 1 : 255;
                else    m_fail = (m_fail < 255) ? m_fail + 1 : 255;
            end
            if (w) begin
                m_pt[wa] = p; m_v[wa] = 1;
            end
            if (ed) m_ct[ca] = c;
        end
        @(posedge clk);
        #1;
        if (chk_model) check_model("model");
    endtask

    task automatic do_reset();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input logic rr);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rr);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic r, w; logic [AW-1:0] wa; logic [PW-1:0] p;
        logic ed; logic [AW-1:0] ca; logic [CW-1:0] c;
        logic dd; logic [AW-1:0] da; logic [CW-1:0] po; logic rr;
        logic ev; logic [RW-1:0] edata; int ep; int ef; logic eo; logic eap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t row(input logic r, input logic w, input int wa, input int p,
                                 input logic ed, input int ca, input int c,
                                 input logic dd, input int da, input int po, input logic rr,
                                 input logic ev, input logic [RW-1:0] edata,
                                 input int ep, input int ef, input logic eo, input logic eap);
        vec_t v;
        v.r = r; v.w = w; v.wa = AW'(wa); v.p = PW'(p);
        v.ed = ed; v.ca = AW'(ca); v.c = CW'(c);
        v.dd = dd; v.da = AW'(da); v.po = CW'(po); v.rr = rr;
        v.ev = ev; v.edata = edata; v.ep = ep; v.ef = ef; v.eo = eo; v.eap = eap;
        return v;
    endfunction

    initial begin
        logic [AW-1:0] ra, rca, rda;
        logic [PW-1:0] rp;
        logic [CW-1:0] rc, rpo;
        logic          rw, red, rdd, rrr, rrst;

        //           r w wa p  ed ca c   dd da po rr   ev edata                    ep ef eo eap
        vecs.push_back(row(1,0,0,0, 0,0,0,  0,0,0, 0,  0,'0,                       0,0,0,0));
        vecs.push_back(row(0,1,1,2, 0,0,0,  0,0,0, 0,  0,'0,                       0,0,0,0));
        vecs.push_back(row(0,0,0,0, 1,1,29, 0,0,0, 0,  0,'0,                       0,0,0,0));
        vecs.push_back(row(0,0,0,0, 0,0,0,  1,1,2, 0,  1,mkrec(1,2,29,2,0,1),      1,0,0,1));
        vecs.push_back(row(0,0,0,0, 0,0,0,  0,0,0, 1,  0,'0,                       1,0,0,1));
        vecs.push_back(row(0,1,3,5, 0,0,0,  0,0,0, 0,  0,'0,                       1,0,0,1));
        vecs.push_back(row(0,0,0,0, 1,3,14, 0,0,0, 0,  0,'0,                       1,0,0,1));
        vecs.push_back(row(0,0,0,0, 0,0,0,  1,3,6, 0,  1,mkrec(3,5,14,6,0,0),      1,1,0,0));
        vecs.push_back(row(0,0,0,0, 0,0,0,  0,0,0, 1,  0,'0,                       1,1,0,0));
        vecs.push_back(row(0,0,0,0, 0,0,0,  1,6,0, 0,  1,mkrec(6,0,0,0,1,0),       1,2,0,0));
        vecs.push_back(row(0,0,0,0, 0,0,0,  0,0,0, 1,  0,'0,                       1,2,0,0));
        vecs.push_back(row(0,1,2,4, 0,0,0,  0,0,0, 0,  0,'0,                       1,2,0,0));
        vecs.push_back(row(0,1,2,9, 0,0,0,  1,2,4, 0,  1,mkrec(2,4,0,4,0,1),       2,2,0,0));
        vecs.push_back(row(0,0,0,0, 0,0,0,  1,2,9, 1,  1,mkrec(2,9,0,9,0,1),       3,2,0,0));
        vecs.push_back(row(0,0,0,0, 0,0,0,  0,0,0, 1,  0,'0,                       3,2,0,0));
        vecs.push_back(row(0,0,0,0, 1,2,17, 1,2,9, 0,  1,mkrec(2,9,0,9,0,1),       4,2,0,0));
        vecs.push_back(row(0,0,0,0, 0,0,0,  1,2,9, 1,  1,mkrec(2,9,17,9,0,1),      5,2,0,0));
        vecs.push_back(row(0,0,0,0, 0,0,0,  0,0,0, 1,  0,'0,                       5,2,0,0));
        vecs.push_back(row(0,0,0,0, 0,0,0,  0,0,0, 1,  0,'0,                       5,2,0,0));
        vecs.push_back(row(0,0,0,0, 0,0,0,  1,1,34,0,  1,mkrec(1,2,29,34,0,0),     5,3,0,0));
        vecs.push_back(row(0,0,0,0, 0,0,0,  0,0,0, 1,  0,'0,                       5,3,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            step(0, v.r, v.w, v.wa, v.p, v.ed, v.ca, v.c, v.dd, v.da, v.po, v.rr);
            chk($sformatf("vec%0d.rec_valid", i), 32'(rec_valid), 32'(v.ev));
            chk($sformatf("vec%0d.rec_data", i),  32'(rec_data),  32'(v.edata));
            chk($sformatf("vec%0d.pass_cnt", i),  32'(pass_cnt),  32'(v.ep));
            chk($sformatf("vec%0d.fail_cnt", i),  32'(fail_cnt),  32'(v.ef));
            chk($sformatf("vec%0d.overflow", i),  32'(overflow),  32'(v.eo));
            chk($sformatf("vec%0d.all_pass", i),  32'(all_pass),  32'(v.eap));
        end

        // ---- overflow with five checks into a four-deep queue, then drain ----
        do_reset();
        for (int k = 0; k < 5; k++) step(1, 0, 1, AW'(k), PW'(k + 3), 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            step(1, 0, 0, 0, 0, 0, 0, 0, 1, AW'(k), (k % 2 == 0) ? CW'(k + 3) : CW'(k + 40), 0);
        chk("ovf.overflow", 32'(overflow), 32'd1);
        chk("ovf.pass_cnt", 32'(pass_cnt), 32'd3);
        chk("ovf.fail_cnt", 32'(fail_cnt), 32'd2);
        chk("ovf.head", 32'(rec_data), 32'(mkrec(0, 3, 0, 3, 0, 1)));
        for (int k = 0; k < 4; k++) idle(1);
        chk("ovf.drained", 32'(rec_valid), 32'd0);

        // ---- full queue with simultaneous pop and push keeps occupancy ----
        do_reset();
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, AW'(k), 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 3'd7, 6'd5, 1);
        chk("fullpp.overflow", 32'(overflow), 32'd0);
        chk("fullpp.fail_cnt", 32'(fail_cnt), 32'd5);
        for (int k = 0; k < 4; k++) idle(1);
        chk("fullpp.last", 32'(rec_valid), 32'd0);

        // ---- reset asserted while a check is in flight ----
        do_reset();
        step(1, 0, 1, 3'd4, 5'd7, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 3'd4, 6'd7, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 3'd5, 6'd1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 3'd4, 6'd7, 0);
        chk("rstmid.rec_valid", 32'(rec_valid), 32'd0);
        chk("rstmid.rec_data",  32'(rec_data),  32'd0);
        chk("rstmid.pass_cnt",  32'(pass_cnt),  32'd0);
        chk("rstmid.fail_cnt",  32'(fail_cnt),  32'd0);
        chk("rstmid.overflow",  32'(overflow),  32'd0);
        idle(0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 3'd4, 6'd7, 0);
        chk("rstmid.shadow_cleared", 32'(rec_data), 32'(mkrec(4, 0, 0, 7, 1, 0)));

        // ---- counter saturation ----
        do_reset();
        for (int k = 0; k < 260; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 3'd6, 6'd0, 1);
        chk("sat.fail_cnt", 32'(fail_cnt), 32'd255);

        // ---- randomized traffic against the model ----
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rrst = ($urandom_range(0, 299) == 0);
            rw   = ($urandom_range(0, 9) < 3);
            ra   = AW'($urandom_range(0, 7));
            rp   = PW'($urandom);
            red  = ($urandom_range(0, 9) < 3);
            rca  = AW'($urandom_range(0, 7));
            rc   = ($urandom_range(0, 3) != 0) ? CW'(mod_pow(m_pt[rca], E_EXP, N_MOD)) : CW'($urandom);
            rdd  = ($urandom_range(0, 9) < 4);
            rda  = AW'($urandom_range(0, 7));
            rpo  = ($urandom_range(0, 3) != 0) ? CW'(mod_pow(m_ct[rda], D_EXP, N_MOD)) : CW'($urandom);
            rrr  = ($urandom_range(0, 9) < 4);
            step(1, rrst, rw, ra, rp, red, rca, rc, rdd, rda, rpo, rrr);
        end

        rst = 1'b0; wren = 1'b0; e_d = 1'b0; d_d = 1'b0; rec_ready = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rsa_result_scoreboard

// File: doc/rsa_result_scoreboard.md
Name: rsa_result_scoreboard

Overview:
- Sits downstream of the RSA encrypt/decrypt datapath.
- Snoops plaintext writes into the input RAM, captures the cipher text on each encryption-done pulse, and checks the recovered plaintext on each decryption-done pulse.
- Each check produces a record that is queued in a small FIFO for readout through a valid/ready port.
- Keeps saturating pass/fail counters and sticky error flags for board display and simulation sign-off.

Parameters:
- ADDR_W, 3, RAM address width; the shadow tables hold 2**ADDR_W entries.
- PT_W, 5, plaintext width.
- CT_W, 6, cipher text and recovered-plaintext width.
- FIFO_DEPTH, 4, record FIFO depth; must be a power of two.
- CNT_W, 8, width of the pass and fail counters.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wren  in  1  plaintext RAM write enable (snooped).
- wraddr  in  ADDR_W  plaintext RAM write address.
- pt  in  PT_W  plaintext being written.
- e_d  in  1  encryption-done pulse.
- ct_addr  in  ADDR_W  address the cipher text belongs to (the encryption read address).
- cipher_text  in  CT_W  cipher text; valid in the cycle e_d=1.
- d_d  in  1  decryption-done pulse.
- dt_addr  in  ADDR_W  address being decrypted.
- pt_org  in  CT_W  recovered plaintext; valid in the cycle d_d=1.
- rec_valid  out  1  FIFO not empty.
- rec_ready  in  1  consumer pops a record when rec_valid=1 and rec_ready=1.
- rec_data  out  ADDR_W+PT_W+2*CT_W+2  head record, packed MSB to LSB as {addr, pt, ct, pt_org, unwritten, match}.
- pass_cnt  out  CNT_W  number of matching checks.
- fail_cnt  out  CNT_W  number of mismatching or unwritten checks.
- overflow  out  1  sticky: a record was dropped because the FIFO was full.
- all_pass  out  1  high when pass_cnt is nonzero, fail_cnt is 0 and overflow is 0.

Behaviour:
- Reset: rst is sampled only at the clock edge. It clears:
  - shadow pt table, ct table and per-address valid bits;
  - FIFO pointers (rec_valid=0, rec_data=0);
  - pass_cnt, fail_cnt, overflow (so all_pass=0).
- Reset asserted mid-operation discards every queued record and every in-flight capture. No partial state survives.
- Snoop: when wren=1, store shadow_pt[wraddr]<=pt and set pt_valid[wraddr] at the next edge.
- Capture: when e_d=1, store shadow_ct[ct_addr]<=cipher_text.
- Check: when d_d=1, form the record combinationally from the current, pre-edge tables:
  - addr = dt_addr;
  - pt = shadow_pt[dt_addr];
  - ct = shadow_ct[dt_addr];
  - pt_org = pt_org;
  - unwritten = !pt_valid[dt_addr];
  - match = pt_valid[dt_addr] && (pt_org == {1'b0, shadow_pt[dt_addr]}).
- Write/read collision: wren and d_d in the same cycle on the same address compare against the OLD shadow value. The new value is visible from the next cycle. The same rule applies to e_d colliding with d_d on the ct table.
- Counters:
  - update on the edge after d_d: match=1 increments pass_cnt, otherwise fail_cnt increments;
  - saturate at all ones (no wrap);
  - update even when the record itself is dropped.
- FIFO:
  - push when d_d=1 and (not full, or a pop happens in the same cycle); full with a simultaneous pop gives a push and pop together, occupancy unchanged;
  - if full with no pop, drop the record and set overflow (sticky until rst);
  - pop on rec_valid && rec_ready;
  - rec_data shows the head entry combinationally from registers;
  - push-to-rec_valid latency is 1 cycle; pop when empty is ignored;
  - pointers are ADDR-wide plus a wrap bit; full when the pointers are equal except the wrap bit.
- A d_d pulse lasting N cycles produces N records. Upstream guarantees single-cycle pulses.

Decomposition:
- Shared package holds:
  - ADDR_W, PT_W, CT_W defaults;
  - RSA constants N_MOD=33, E_EXP=7, D_EXP=3 (for the bench model);
  - record field offsets and REC_W.
- One sub-module: rsa_rec_fifo, a synchronous FIFO with parameters WIDTH and DEPTH and ports push/pop/full/empty/head.
- The top holds the shadow tables, compare logic and counters.

Test Plan:
- Write pt=2 to addr 1; e_d with ct_addr=1, cipher_text=29; d_d with dt_addr=1, pt_org=2 -> one record {1,2,29,2,0,1}, pass_cnt=1, all_pass=1.
- Write pt=5 to addr 3; e_d ct=14; d_d pt_org=6 -> record match=0, fail_cnt=1, all_pass=0.
- d_d on never-written addr 6 with pt_org=0 -> unwritten=1, match=0, fail_cnt+1.
- rec_ready=0, five d_d pulses -> 4 records queued, overflow=1, counters advance by 5; then drain with rec_ready=1 -> records come out in FIFO order, rec_valid falls after the 4th pop.
- Same cycle: wren addr 2 pt=9 and d_d addr 2, with old shadow 4 and pt_org=4 -> match=1. Next check of addr 2 compares against 9.
- Fill 2 records, assert rst for one cycle during a d_d -> next cycle rec_valid=0, counters=0, overflow=0, no record from that d_d.
